// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the time-setting controller: state encoding,
// field-select codes, field limits and widths.
package clock_set_ctrl_pkg;

    localparam int HOUR_W  = 5;
    localparam int MS_W    = 6;
    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_SEC  = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_HOUR = 2'b01;
    localparam logic [1:0] SEL_MIN  = 2'b10;
    localparam logic [1:0] SEL_SEC  = 2'b11;

    function automatic logic is_edit_state(input state_t s);
        return (s == ST_SET_HOUR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_wrap_inc.sv
// Conditional increment with wrap to zero past MAX; used for each time field.
module wrap_inc #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic [W-1:0] val,
    input  logic         en,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = val;
        if (en) begin
            nxt = (val == W'(MAX)) ? '0 : val + W'(1);
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: walks hour/min/sec editing from key pulses,
// aborts after TIMEOUT_S idle seconds, and pulses load on commit.
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int TIMEOUT_S = 10,
    parameter int HOUR_MAX  = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_shift,
    input  logic              set_time,
    input  logic              tick_1hz,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MS_W-1:0]   cur_min,
    input  logic [MS_W-1:0]   cur_sec,
    output logic              edit_mode,
    output logic [1:0]        sel,
    output logic [HOUR_W-1:0] edit_hour,
    output logic [MS_W-1:0]   edit_min,
    output logic [MS_W-1:0]   edit_sec,
    output logic              load,
    output logic              blink
);

    state_t            state_reg, state_next;
    logic [5:0]        cnt_reg, cnt_next;
    logic              blink_reg, blink_next;
    logic              load_reg, load_next;
    logic [HOUR_W-1:0] hour_reg, hour_next, hour_inc;
    logic [MS_W-1:0]   min_reg, min_next, min_inc;
    logic [MS_W-1:0]   sec_reg, sec_next, sec_inc;

    // set_shift takes priority, so an increment only happens on a lone set_time
    logic inc_ok;
    assign inc_ok = set_time && !set_shift;

    wrap_inc #(.W(HOUR_W), .MAX(HOUR_MAX)) u_inc_hour (
        .val (hour_reg),
        .en  (inc_ok && (state_reg == ST_SET_HOUR)),
        .nxt (hour_inc)
    );

    wrap_inc #(.W(MS_W), .MAX(MIN_MAX)) u_inc_min (
        .val (min_reg),
        .en  (inc_ok && (state_reg == ST_SET_MIN)),
        .nxt (min_inc)
    );

    wrap_inc #(.W(MS_W), .MAX(SEC_MAX)) u_inc_sec (
        .val (sec_reg),
        .en  (inc_ok && (state_reg == ST_SET_SEC)),
        .nxt (sec_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
            blink_reg <= 1'b0;
            load_reg  <= 1'b0;
            hour_reg  <= '0;
            min_reg   <= '0;
            sec_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            blink_reg <= blink_next;
            load_reg  <= load_next;
            hour_reg  <= hour_next;
            min_reg   <= min_next;
            sec_reg   <= sec_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        blink_next = 1'b0;
        load_next  = 1'b0;
        hour_next  = hour_reg;
        min_next   = min_reg;
        sec_next   = sec_reg;

        case (state_reg)
            ST_RUN: begin
                cnt_next = '0;
                if (set_shift) begin
                    state_next = ST_SET_HOUR;
                    hour_next  = cur_hour;
                    min_next   = cur_min;
                    sec_next   = cur_sec;
                end
            end
            ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC: begin
                hour_next = hour_inc;
                min_next  = min_inc;
                sec_next  = sec_inc;
                if (set_shift) begin
                    case (state_reg)
                        ST_SET_HOUR: state_next = ST_SET_MIN;
                        ST_SET_MIN:  state_next = ST_SET_SEC;
                        default: begin
                            state_next = ST_COMMIT;
                            load_next  = 1'b1;
                        end
                    endcase
                end
                // A key pulse on the final tick clears the counter and cancels the abort
                if (set_shift || set_time) begin
                    cnt_next = '0;
                end else if (tick_1hz) begin
                    if (cnt_reg == 6'(TIMEOUT_S - 1)) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 6'd1;
                    end
                end
                if (is_edit_state(state_next)) begin
                    blink_next = blink_reg ^ tick_1hz;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        sel = SEL_NONE;
        case (state_reg)
            ST_SET_HOUR: sel = SEL_HOUR;
            ST_SET_MIN:  sel = SEL_MIN;
            ST_SET_SEC:  sel = SEL_SEC;
            default:     sel = SEL_NONE;
        endcase
    end

    assign edit_mode = is_edit_state(state_reg);
    assign edit_hour = hour_reg;
    assign edit_min  = min_reg;
    assign edit_sec  = sec_reg;
    assign load      = load_reg;
    assign blink     = blink_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus a random
// key/tick stream compared against a behavioural edit-session model.
module tb_clock_set_ctrl;

    localparam int TO = 10;
    localparam int HM = 23;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       set_shift = 1'b0;
    logic       set_time = 1'b0;
    logic       tick_1hz = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic       edit_mode;
    logic [1:0] sel;
    logic [4:0] edit_hour;
    logic [5:0] edit_min;
    logic [5:0] edit_sec;
    logic       load;
    logic       blink;

    int n_tests = 0;
    int n_fail = 0;
    int load_count = 0;

    // model: mode 0 = running, 1..3 = editing hour/min/sec, 4 = commit cycle
    int m_mode, m_h, m_m, m_s, m_idle;
    bit m_blink;

    clock_set_ctrl #(.TIMEOUT_S(TO), .HOUR_MAX(HM)) dut (
        .clk       (clk),
        .rst       (rst),
        .set_shift (set_shift),
        .set_time  (set_time),
        .tick_1hz  (tick_1hz),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .cur_sec   (cur_sec),
        .edit_mode (edit_mode),
        .sel       (sel),
        .edit_hour (edit_hour),
        .edit_min  (edit_min),
        .edit_sec  (edit_sec),
        .load      (load),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) load_count++;

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0; m_blink = 0;
    endtask

    task automatic model_step();
        int fld;
        if (m_mode == 0) begin
            if (set_shift) begin
                m_mode = 1; m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
                m_idle = 0;
            end
            m_blink = 0;
        end else if (m_mode == 4) begin
            m_mode = 0; m_blink = 0;
        end else if (set_shift) begin
            m_mode = m_mode + 1;
            m_idle = 0;
            m_blink = (m_mode <= 3) ? (m_blink ^ tick_1hz) : 1'b0;
        end else if (set_time) begin
            fld = m_mode;
            if (fld == 1) m_h = (m_h + 1) % (HM + 1);
            if (fld == 2) m_m = (m_m + 1) % 60;
            if (fld == 3) m_s = (m_s + 1) % 60;
            m_idle = 0;
            m_blink = m_blink ^ tick_1hz;
        end else if (tick_1hz) begin
            m_idle = m_idle + 1;
            if (m_idle == TO) begin
                m_mode = 0; m_idle = 0; m_blink = 0;
            end else begin
                m_blink = ~m_blink;
            end
        end
    endtask

    task automatic step(input bit s, input bit t, input bit k);
        @(negedge clk);
        set_shift = s; set_time = t; tick_1hz = k;
        @(posedge clk);
        model_step();
        #1;
        set_shift = 0; set_time = 0; tick_1hz = 0;
        $display("[TB] %0t shift=%0b time=%0b tick=%0b -> mode=%0b sel=%0d edit=%0d:%0d:%0d load=%0b blink=%0b",
                 $time, s, t, k, edit_mode, sel, edit_hour, edit_min, edit_sec, load, blink);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        #2;
        rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({edit_mode, sel, edit_hour, edit_min, edit_sec, load, blink} !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {edit_mode, sel, edit_hour, edit_min, edit_sec, load, blink});
        end
        #2 rst = 0;
        model_reset();
    endtask

    task automatic test_enter();
        do_reset();
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        step(1, 0, 0);
        n_tests++;
        if ({edit_mode, sel, blink} !== 4'b1010) begin
            n_fail++;
            $display("FAIL enter_state: got mode=%0b sel=%0d blink=%0b required 1/1/0", edit_mode, sel, blink);
        end
        n_tests++;
        if ({edit_hour, edit_min, edit_sec} !== {5'd12, 6'd34, 6'd56}) begin
            n_fail++;
            $display("FAIL enter_capture: got %0d:%0d:%0d required 12:34:56", edit_hour, edit_min, edit_sec);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd0;
        step(1, 0, 0);
        step(0, 1, 0);
        n_tests++;
        if (edit_hour !== 5'd0) begin
            n_fail++;
            $display("FAIL hour_wrap: got %0d required 0", edit_hour);
        end
        step(1, 0, 0);
        n_tests++;
        if (sel !== 2'b10 || edit_min !== 6'd59) begin
            n_fail++;
            $display("FAIL to_min: got sel=%0d min=%0d required 2/59", sel, edit_min);
        end
        step(0, 1, 0);
        step(0, 1, 0);
        n_tests++;
        if (edit_min !== 6'd1 || edit_hour !== 5'd0) begin
            n_fail++;
            $display("FAIL min_wrap: got min=%0d hour=%0d required 1/0", edit_min, edit_hour);
        end
    endtask

    task automatic test_commit();
        int lc0;
        do_reset();
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        n_tests++;
        if (sel !== 2'b11 || edit_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sec: got sel=%0d mode=%0b required 3/1", sel, edit_mode);
        end
        repeat (3) step(0, 1, 0);
        n_tests++;
        if (edit_sec !== 6'd59) begin
            n_fail++;
            $display("FAIL sec_inc: got %0d required 59", edit_sec);
        end
        lc0 = load_count;
        step(1, 0, 0);
        n_tests++;
        if ({load, edit_mode, sel} !== 4'b1000 || {edit_hour, edit_min, edit_sec} !== {5'd12, 6'd34, 6'd59}) begin
            n_fail++;
            $display("FAIL commit_cycle: got load=%0b mode=%0b sel=%0d edit=%0d:%0d:%0d required 1/0/0 12:34:59",
                     load, edit_mode, sel, edit_hour, edit_min, edit_sec);
        end
        step(0, 0, 0);
        n_tests++;
        if ({load, edit_mode, sel} !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_commit: got load=%0b mode=%0b sel=%0d required 0/0/0", load, edit_mode, sel);
        end
        repeat (3) step(0, 0, 0);
        n_tests++;
        if (load_count - lc0 !== 1) begin
            n_fail++;
            $display("FAIL load_once: got %0d load cycles required 1", load_count - lc0);
        end
    endtask

    task automatic test_timeout();
        int lc0;
        do_reset();
        lc0 = load_count;
        cur_hour = 5'd3; cur_min = 6'd4; cur_sec = 6'd5;
        // plain timeout
        step(1, 0, 0); step(1, 0, 0);
        repeat (TO - 1) step(0, 0, 1);
        n_tests++;
        if (edit_mode !== 1'b1 || sel !== 2'b10) begin
            n_fail++;
            $display("FAIL timeout_early: got mode=%0b sel=%0d required 1/2", edit_mode, sel);
        end
        step(0, 0, 1);
        n_tests++;
        if ({edit_mode, sel, blink, load} !== 5'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got mode=%0b sel=%0d blink=%0b load=%0b required 0", edit_mode, sel, blink, load);
        end
        // set_time after the 9th tick restarts the count
        step(1, 0, 0); step(1, 0, 0);
        repeat (TO - 1) step(0, 0, 1);
        step(0, 1, 0);
        repeat (TO - 1) step(0, 0, 1);
        n_tests++;
        if (edit_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_restart: got mode=%0b required 1", edit_mode);
        end
        step(0, 0, 1);
        n_tests++;
        if (edit_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_restart_abort: got mode=%0b required 0", edit_mode);
        end
        // key on the final tick wins
        step(1, 0, 0); step(1, 0, 0);
        repeat (TO - 1) step(0, 0, 1);
        step(0, 1, 1);
        n_tests++;
        if (edit_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL key_beats_tick: got mode=%0b required 1", edit_mode);
        end
        repeat (TO - 1) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        n_tests++;
        if (edit_mode !== 1'b0 || load_count !== lc0) begin
            n_fail++;
            $display("FAIL timeout_no_load: got mode=%0b loads=%0d required 0/0", edit_mode, load_count - lc0);
        end
    endtask

    task automatic test_simul();
        do_reset();
        cur_hour = 5'd5; cur_min = 6'd10; cur_sec = 6'd20;
        step(1, 0, 0);
        step(1, 1, 0);
        n_tests++;
        if (sel !== 2'b10 || edit_hour !== 5'd5 || edit_min !== 6'd10) begin
            n_fail++;
            $display("FAIL shift_wins: got sel=%0d hour=%0d min=%0d required 2/5/10", sel, edit_hour, edit_min);
        end
    endtask

    task automatic test_async_reset();
        int lc0;
        do_reset();
        cur_hour = 5'd1; cur_min = 6'd2; cur_sec = 6'd3;
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
        step(0, 1, 1);
        lc0 = load_count;
        @(negedge clk);
        #2 rst = 1;
        #1;
        n_tests++;
        if ({edit_mode, sel, edit_hour, edit_min, edit_sec, load, blink} !== 22'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", {edit_mode, sel, edit_hour, edit_min, edit_sec, load, blink});
        end
        @(posedge clk);
        @(negedge clk);
        #2 rst = 0;
        model_reset();
        repeat (5) step(0, 0, 0);
        n_tests++;
        if (load_count !== lc0 || edit_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_load: got loads=%0d mode=%0b required 0/0", load_count - lc0, edit_mode);
        end
    endtask

    task automatic test_random();
        int p;
        bit s, t, k;
        logic       e_mode, e_load;
        logic [1:0] e_sel;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cur_hour = 5'($urandom_range(0, HM));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
            p = (i < 300) ? 6 : 40;
            s = ($urandom_range(0, p - 1) == 0);
            t = ($urandom_range(0, p - 1) == 0);
            k = ($urandom_range(0, 2) == 0);
            step(s, t, k);
            e_mode = (m_mode >= 1 && m_mode <= 3);
            e_sel  = e_mode ? 2'(m_mode) : 2'b00;
            e_load = (m_mode == 4);
            n_tests++;
            if (edit_mode !== e_mode || sel !== e_sel || load !== e_load || blink !== m_blink ||
                edit_hour !== 5'(m_h) || edit_min !== 6'(m_m) || edit_sec !== 6'(m_s)) begin
                n_fail++;
                $display("FAIL random_%0d: got mode=%0b sel=%0d load=%0b blink=%0b edit=%0d:%0d:%0d required %0b/%0d/%0b/%0b %0d:%0d:%0d",
                         i, edit_mode, sel, load, blink, edit_hour, edit_min, edit_sec,
                         e_mode, e_sel, e_load, m_blink, m_h, m_m, m_s);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_enter();
        test_wrap();
        test_commit();
        test_timeout();
        test_simul();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
